program_loader: RTL and testbench

Sequencing controller that fills the processor's writable program memory from an external byte stream, then releases the core to run. It sits between a byte source (UART receiver or bench driver) and the write port of the instruction ROM/RAM. It holds the core stalled while loading, assembles little-endian bytes into instruction words, issues one word-aligned write per word, and raises the run signal when the requested word count has been written.

---
 rtl/program_loader.sv | 100 ++++++++++
 tb/tb_program_loader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Program memory loader: assembles little-endian bytes into words, writes them to
// instruction memory while holding the core stalled, then releases it to run.
module program_loader #(
    parameter int unsigned MEMORY_DEPTH = 32,
    parameter int unsigned DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  LoadStart,
    input  logic [DATA_WIDTH-1:0] NumWords,
    input  logic [7:0]            ByteIn,
    input  logic                  ByteValid,
    output logic                  ByteReady,
    output logic                  WriteEnable,
    output logic [DATA_WIDTH-1:0] WriteAddress,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic                  CpuStall,
    output logic                  CpuRun,
    output logic                  Busy
);

    localparam int unsigned IdxW = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(MEMORY_DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [IdxW-1:0]       word_idx_q, word_idx_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [CntW-1:0]       clamped;
    logic                  last_word;

    assign clamped   = (NumWords > DATA_WIDTH'(MEMORY_DEPTH)) ? CntW'(MEMORY_DEPTH)
                                                              : NumWords[CntW-1:0];
    assign last_word = (CntW'(word_idx_q) + CntW'(1)) == count_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (LoadStart) begin
                    count_d    = clamped;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    state_d    = (clamped == '0) ? StDone : StLoad;
                end
            end
            StLoad: begin
                if (ByteValid) begin
                    word_d[8*byte_idx_q +: 8] = ByteIn;
                    byte_idx_d                = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                // Index is held on the last word so the address never wraps.
                if (last_word) begin
                    state_d = StDone;
                end else begin
                    word_idx_d = word_idx_q + IdxW'(1);
                    state_d    = StLoad;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            count_q    <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
        end
    end

    assign ByteReady    = (state_q == StLoad);
    assign WriteEnable  = (state_q == StWrite);
    assign Busy         = (state_q == StLoad) || (state_q == StWrite);
    assign CpuStall     = Busy;
    assign CpuRun       = (state_q == StDone);
    assign WriteAddress = DATA_WIDTH'({word_idx_q, 2'b00});
    assign WriteData    = word_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: byte-count reference model checked every cycle, plus
// directed loads with literal expectations.
module tb_program_loader;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        LoadStart;
    logic [31:0] NumWords;
    logic [7:0]  ByteIn;
    logic        ByteValid;
    logic        ByteReady, WriteEnable, CpuStall, CpuRun, Busy;
    logic [31:0] WriteAddress, WriteData;

    always #5 clk = ~clk;

    program_loader #(.MEMORY_DEPTH(DEPTH), .DATA_WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .LoadStart   (LoadStart),
        .NumWords    (NumWords),
        .ByteIn      (ByteIn),
        .ByteValid   (ByteValid),
        .ByteReady   (ByteReady),
        .WriteEnable (WriteEnable),
        .WriteAddress(WriteAddress),
        .WriteData   (WriteData),
        .CpuStall    (CpuStall),
        .CpuRun      (CpuRun),
        .Busy        (Busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a load is described by how many bytes were taken and words written.
    bit         m_loading, m_done;
    int         m_total, m_acc, m_wr;
    logic [7:0] m_buf[0:255];

    logic [7:0]  src[$];
    logic [63:0] cap[$];
    int          busy_cycles;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_loading = 0;
        m_done    = 0;
        m_total   = 0;
        m_acc     = 0;
        m_wr      = 0;
    endtask

    task automatic compare_outputs();
        bit pend;
        int w;
        pend = m_loading && (m_acc == 4 * (m_wr + 1));
        w    = m_wr;
        chk("ByteReady", 64'(ByteReady), 64'(m_loading && !pend));
        chk("WriteEnable", 64'(WriteEnable), 64'(pend));
        chk("Busy", 64'(Busy), 64'(m_loading));
        chk("CpuStall", 64'(CpuStall), 64'(m_loading));
        chk("CpuRun", 64'(CpuRun), 64'(m_done));
        if (pend) begin
            chk("WriteAddress", 64'(WriteAddress), 64'(w * 4));
            chk("WriteData", 64'(WriteData),
                64'({m_buf[4*w+3], m_buf[4*w+2], m_buf[4*w+1], m_buf[4*w]}));
        end
        if (WriteEnable) cap.push_back({WriteAddress, WriteData});
        if (Busy) busy_cycles++;
    endtask

    task automatic model_step(input logic ls, input logic [31:0] nw, input logic bv,
                              input logic [7:0] bi);
        if (!m_loading) begin
            if (ls) begin
                m_total   = (nw > 32'(DEPTH)) ? DEPTH : int'(nw);
                m_acc     = 0;
                m_wr      = 0;
                m_loading = (m_total != 0);
                m_done    = (m_total == 0);
            end
        end else if (m_acc == 4 * (m_wr + 1)) begin
            m_wr++;
            if (m_wr == m_total) begin
                m_loading = 0;
                m_done    = 1;
            end
        end else if (bv) begin
            m_buf[m_acc] = bi;
            m_acc++;
            if (src.size() > 0) void'(src.pop_front());
        end
    endtask

    // One clock: check at the falling edge, drive, advance the model on the rising edge.
    task automatic cyc(input logic ls, input logic [31:0] nw, input logic bv);
        compare_outputs();
        LoadStart = ls;
        NumWords  = nw;
        ByteValid = bv;
        ByteIn    = (src.size() > 0) ? src[0] : 8'($urandom);
        @(posedge clk);
        model_step(ls, nw, bv, ByteIn);
        @(negedge clk);
    endtask

    task automatic run_load(input int mode);
        int   n;
        logic bv;
        logic ls;
        n = 0;
        while (m_loading && n < 2000) begin
            case (mode)
                0:       bv = 1'b1;
                1:       bv = (n % 2) == 0;
                default: bv = ($urandom_range(0, 3) != 0);
            endcase
            ls = (mode != 0) && ($urandom_range(0, 9) == 0);
            cyc(ls, 32'($urandom_range(0, 9)), bv);
            n++;
        end
        if (m_loading) begin
            n_bad++;
            $display("FAIL load_timeout: still loading after %0d cycles, required done", n);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ByteReady"}, 64'(ByteReady), 64'(0));
        chk({tag, "_WriteEnable"}, 64'(WriteEnable), 64'(0));
        chk({tag, "_Busy"}, 64'(Busy), 64'(0));
        chk({tag, "_CpuStall"}, 64'(CpuStall), 64'(0));
        chk({tag, "_CpuRun"}, 64'(CpuRun), 64'(0));
        chk({tag, "_WriteAddress"}, 64'(WriteAddress), 64'(0));
        chk({tag, "_WriteData"}, 64'(WriteData), 64'(0));
    endtask

    task automatic async_reset(input string tag);
        #2 reset = 1'b0;
        #1 check_reset_outputs(tag);
        model_clear();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic push_bytes(input logic [31:0] w);
        for (int i = 0; i < 4; i++) src.push_back(w[8*i +: 8]);
    endtask

    initial begin
        reset     = 1'b0;
        LoadStart = 1'b0;
        NumWords  = '0;
        ByteIn    = '0;
        ByteValid = 1'b0;
        model_clear();
        #1 check_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Two words back-to-back.
        push_bytes(32'h20000013);
        push_bytes(32'h12345678);
        cap.delete();
        busy_cycles = 0;
        cyc(1'b1, 32'd2, 1'b0);
        run_load(0);
        cyc(1'b0, 32'd0, 1'b0);
        chk("b2b_busy_cycles", 64'(busy_cycles), 64'(10));
        chk("b2b_nwrites", 64'(cap.size()), 64'(2));
        if (cap.size() == 2) begin
            chk("b2b_w0", cap[0], 64'h00000000_20000013);
            chk("b2b_w1", cap[1], 64'h00000004_12345678);
        end

        // Restart from DONE with ByteValid toggling and stray LoadStart pulses.
        push_bytes(32'h20000013);
        push_bytes(32'h12345678);
        cap.delete();
        cyc(1'b1, 32'd2, 1'b0);
        run_load(1);
        cyc(1'b0, 32'd0, 1'b0);
        chk("tog_nwrites", 64'(cap.size()), 64'(2));
        if (cap.size() == 2) begin
            chk("tog_w0", cap[0], 64'h00000000_20000013);
            chk("tog_w1", cap[1], 64'h00000004_12345678);
        end

        // Zero-word load from IDLE.
        async_reset("rst0");
        cap.delete();
        cyc(1'b1, 32'd0, 1'b1);
        chk("zero_run", 64'(CpuRun), 64'(1));
        cyc(1'b0, 32'd0, 1'b1);
        chk("zero_nwrites", 64'(cap.size()), 64'(0));

        // Clamp: 40 requested, 160 bytes offered.
        src.delete();
        for (int i = 0; i < 160; i++) src.push_back(8'($urandom));
        cap.delete();
        cyc(1'b1, 32'd40, 1'b0);
        run_load(0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'd0, 1'b1);
        chk("clamp_nwrites", 64'(cap.size()), 64'(32));
        if (cap.size() == 32) chk("clamp_last_addr", 64'(cap[31][63:32]), 64'h7C);
        chk("clamp_leftover", 64'(src.size()), 64'(32));
        src.delete();

        // Reset partway through a word, then reload with fresh bytes.
        async_reset("rst1");
        src.push_back(8'h11);
        src.push_back(8'h22);
        cap.delete();
        cyc(1'b1, 32'd1, 1'b0);
        cyc(1'b0, 32'd0, 1'b1);
        cyc(1'b0, 32'd0, 1'b1);
        async_reset("rst_mid");
        chk("mid_nwrites", 64'(cap.size()), 64'(0));
        push_bytes(32'hDDCCBBAA);
        cyc(1'b1, 32'd1, 1'b0);
        run_load(0);
        cyc(1'b0, 32'd0, 1'b0);
        chk("fresh_nwrites", 64'(cap.size()), 64'(1));
        if (cap.size() == 1) chk("fresh_w0", cap[0], 64'h00000000_DDCCBBAA);

        // Randomised loads.
        for (int k = 0; k < 10; k++) begin
            int nw;
            nw = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 90) : $urandom_range(0, 6);
            src.delete();
            for (int i = 0; i < 4 * nw + 8; i++) src.push_back(8'($urandom));
            cyc(1'b1, 32'(nw), 1'($urandom_range(0, 1)));
            run_load(2);
            for (int i = 0; i < 3; i++) cyc(1'b0, 32'($urandom), 1'($urandom_range(0, 1)));
        end
        cyc(1'b0, 32'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
